// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and word width.
package mips_pkg;

  localparam int INS_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; exposes the word completed by the current byte.
module imem_loader_word_packer
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic [7:0]       data,
  output logic [INS_W-1:0] word,
  output logic             last
);

  logic [INS_W-9:0] asm_q;
  logic [1:0]       idx;

  // Only the first three bytes need storing; the fourth is taken straight from the input.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      asm_q <= '0;
      idx   <= '0;
    end else if (shift) begin
      asm_q <= {asm_q[INS_W-17:0], data};
      idx   <= idx + 2'd1;
    end
  end

  assign word = {asm_q, data};
  assign last = (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// UART byte-stream program loader: frames count/payload/checksum and writes instruction memory.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              we,
  output logic [INS_W-1:0]  w_ins,
  output logic [ADDR_W-1:0] w_addr,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT - 1);
  localparam logic [16:0]     CAP  = 17'(1 << ADDR_W);

  loader_state_t    state;
  logic [15:0]      n_q;
  logic [15:0]      wcnt;
  logic [7:0]       chk;
  logic [TW-1:0]    timer;
  logic [15:0]      n_next;
  logic             arm;
  logic [INS_W-1:0] word;
  logic             last;

  assign n_next = {n_q[7:0], rx_data};
  assign arm    = start && (state == IDLE || state == DONE || state == ERR);

  imem_loader_word_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .shift (rx_valid && state == DATA),
    .data  (rx_data),
    .word  (word),
    .last  (last)
  );

  // A byte arriving in the timeout cycle is accepted; the timeout only fires on an idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_q      <= '0;
      wcnt     <= '0;
      chk      <= '0;
      timer    <= '0;
      we       <= 1'b0;
      w_ins    <= '0;
      w_addr   <= '0;
      core_rst <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= CNT_HI;
            core_rst <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            chk      <= '0;
            timer    <= '0;
            wcnt     <= '0;
          end
        end
        default: begin
          if (rx_valid) begin
            timer <= '0;
            case (state)
              CNT_HI: begin
                n_q   <= n_next;
                state <= CNT_LO;
              end
              CNT_LO: begin
                n_q <= n_next;
                if (n_next == 16'd0) begin
                  state <= CHK;
                end else if ({1'b0, n_next} > CAP) begin
                  state <= ERR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  state <= DATA;
                end
              end
              DATA: begin
                chk <= chk ^ rx_data;
                if (last) begin
                  we     <= 1'b1;
                  w_ins  <= word;
                  w_addr <= wcnt[ADDR_W-1:0];
                  wcnt   <= wcnt + 16'd1;
                  if (wcnt == n_q - 16'd1) begin
                    state <= CHK;
                  end
                end
              end
              CHK: begin
                busy <= 1'b0;
                if (rx_data == chk) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  core_rst <= 1'b0;
                end else begin
                  state <= ERR;
                  err   <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (timer == TLIM) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
